lcd_text_feeder: RTL and testbench

//   Upstream feeder for the 2x16 character LCD controller. Holds a 32-byte text buffer
//   (2 lines x 16 cols) that the CPU writes through a memory-mapped port.

---
 rtl/lcd_text_feeder.sv | 130 +++++++++++++
 tb/tb_lcd_text_feeder.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_text_feeder.sv
// Feeds a 2x16 text buffer to the character LCD controller, one whole line at a time,
// over the line/char/flag/done handshake; lcd_done arrives from a slower clock domain.
module lcd_text_feeder #(
   parameter logic [7:0] BLANK_CHAR  = 8'h20,
   parameter int         SYNC_STAGES = 2
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       wr_en,
   input  logic [4:0] wr_addr,
   input  logic [7:0] wr_data,
   input  logic       clr,
   input  logic [4:0] rd_addr,
   output logic [7:0] rd_data,
   output logic       lcd_line,
   output logic [7:0] lcd_char,
   output logic       lcd_flag,
   input  logic       lcd_done,
   output logic       busy
);

   typedef enum logic [1:0] {S_IDLE, S_FETCH, S_WAIT} state_t;

   state_t                 state_q, state_d;
   logic [7:0]             text_q [32];
   logic [1:0]             dirty_q, dirty_d;
   logic [3:0]             col_q, col_d;
   logic                   cur_line_q, cur_line_d;
   logic [7:0]             lcd_char_q, lcd_char_d;
   logic                   lcd_line_q, lcd_line_d;
   logic                   lcd_flag_q, lcd_flag_d;
   logic [SYNC_STAGES-1:0] sync_q;
   logic                   synced_q;
   logic                   done_rise;
   logic                   sel;

   assign done_rise = sync_q[SYNC_STAGES-1] & ~synced_q;
   // Line 0 always wins when both lines are dirty.
   assign sel       = ~dirty_q[0];

   assign rd_data  = text_q[rd_addr];
   assign lcd_line = lcd_line_q;
   assign lcd_char = lcd_char_q;
   assign lcd_flag = lcd_flag_q;
   assign busy     = (state_q != S_IDLE) || (dirty_q != 2'b00);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < 32; i++) text_q[i] <= BLANK_CHAR;
      end else if (clr) begin
         for (int i = 0; i < 32; i++) text_q[i] <= BLANK_CHAR;
      end else if (wr_en) begin
         text_q[wr_addr] <= wr_data;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         sync_q   <= '0;
         synced_q <= 1'b0;
      end else begin
         sync_q   <= {sync_q[SYNC_STAGES-2:0], lcd_done};
         synced_q <= sync_q[SYNC_STAGES-1];
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q    <= S_IDLE;
         dirty_q    <= 2'b11;
         col_q      <= 4'd0;
         cur_line_q <= 1'b0;
         lcd_char_q <= 8'h00;
         lcd_line_q <= 1'b0;
         lcd_flag_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         dirty_q    <= dirty_d;
         col_q      <= col_d;
         cur_line_q <= cur_line_d;
         lcd_char_q <= lcd_char_d;
         lcd_line_q <= lcd_line_d;
         lcd_flag_q <= lcd_flag_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (dirty_q != 2'b00) state_d = S_FETCH;
         S_FETCH: state_d = S_WAIT;
         S_WAIT:  if (done_rise) state_d = (col_q == 4'd15) ? S_IDLE : S_FETCH;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      dirty_d    = dirty_q;
      col_d      = col_q;
      cur_line_d = cur_line_q;
      lcd_char_d = lcd_char_q;
      lcd_line_d = lcd_line_q;
      lcd_flag_d = lcd_flag_q;
      case (state_q)
         S_IDLE: begin
            if (dirty_q != 2'b00) begin
               cur_line_d   = sel;
               dirty_d[sel] = 1'b0;
               col_d        = 4'd0;
            end
         end
         S_FETCH: begin
            lcd_char_d = text_q[{cur_line_q, col_q}];
            lcd_line_d = cur_line_q;
            lcd_flag_d = 1'b1;
         end
         S_WAIT: begin
            if (done_rise) begin
               lcd_flag_d = 1'b0;
               if (col_q != 4'd15) col_d = col_q + 4'd1;
            end
         end
         default: ;
      endcase
      // A write landing on the line being selected must survive, so the whole line is re-sent.
      if (clr)        dirty_d = 2'b11;
      else if (wr_en) dirty_d[wr_addr[4]] = 1'b1;
   end

endmodule

// File: tb/tb_lcd_text_feeder.sv
module tb_lcd_text_feeder;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       wr_en = 1'b0;
   logic [4:0] wr_addr = '0;
   logic [7:0] wr_data = '0;
   logic       clr = 1'b0;
   logic [4:0] rd_addr = '0;
   logic [7:0] rd_data;
   logic       lcd_line;
   logic [7:0] lcd_char;
   logic       lcd_flag;
   logic       lcd_done;
   logic       busy;

   logic resp_done = 1'b0;
   logic hold_done = 1'b0;
   logic auto_en   = 1'b0;
   assign lcd_done = resp_done | hold_done;

   int total = 0;
   int bad = 0;
   int req_count = 0;
   logic [8:0] exp_q [$];
   logic [7:0] mem [32];
   logic prev_flag = 1'b0;

   lcd_text_feeder dut (
      .clock(clock), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .clr(clr), .rd_addr(rd_addr), .rd_data(rd_data), .lcd_line(lcd_line),
      .lcd_char(lcd_char), .lcd_flag(lcd_flag), .lcd_done(lcd_done), .busy(busy)
   );

   always #5 clock = ~clock;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Controller model: answers a raised flag after 8..12 clocks with a 4..6 clock done pulse.
   initial begin
      int phase = 0;
      int cnt = 0;
      forever begin
         @(negedge clock);
         if (!auto_en || reset) begin
            phase = 0; cnt = 0; resp_done = 1'b0;
         end else begin
            case (phase)
               0: if (lcd_flag) begin cnt = $urandom_range(12, 8); phase = 1; end
               1: begin
                  cnt--;
                  if (cnt == 0) begin resp_done = 1'b1; cnt = $urandom_range(6, 4); phase = 2; end
               end
               default: begin
                  cnt--;
                  if (cnt == 0) begin resp_done = 1'b0; phase = 0; end
               end
            endcase
         end
      end
   end

   // Monitor: every new request is compared with the head of the scoreboard.
   initial begin
      logic [8:0] e;
      forever begin
         @(negedge clock);
         if (!reset && lcd_flag && !prev_flag) begin
            req_count++;
            if (exp_q.size() == 0) begin
               total++; bad++;
               $display("FAIL unexpected_req: got line %0d char %0h, nothing expected", lcd_line, lcd_char);
            end else begin
               e = exp_q.pop_front();
               check("req_line_char", {23'd0, lcd_line, lcd_char}, {23'd0, e});
            end
         end
         prev_flag = lcd_flag;
      end
   end

   task automatic push_line(input int l);
      for (int c = 0; c < 16; c++) exp_q.push_back({l[0], mem[l * 16 + c]});
   endtask

   task automatic blank_mem();
      for (int i = 0; i < 32; i++) mem[i] = 8'h20;
   endtask

   task automatic do_write(input logic [4:0] a, input logic [7:0] d, input logic we, input logic c);
      @(negedge clock);
      wr_addr = a; wr_data = d; wr_en = we; clr = c;
      @(negedge clock);
      wr_en = 1'b0; clr = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      int n = 0;
      while ((busy || exp_q.size() != 0) && n < 5000) begin
         @(negedge clock);
         n++;
      end
      total++;
      if (n >= 5000) begin
         bad++;
         $display("FAIL %s: still busy=%0d pending=%0d after 5000 cycles, idle required", name, busy, exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic wait_req(input int target, input string name);
      int n = 0;
      while (req_count < target && n < 5000) begin
         @(negedge clock);
         n++;
      end
      total++;
      if (n >= 5000) begin
         bad++;
         $display("FAIL %s: req_count=%0d required %0d", name, req_count, target);
      end
   endtask

   initial begin
      int base;
      int lat;
      logic [4:0] a;
      logic [7:0] d;

      blank_mem();
      repeat (3) @(negedge clock);
      check("reset_flag", {31'd0, lcd_flag}, 32'd0);
      check("reset_char", {24'd0, lcd_char}, 32'd0);
      check("reset_line", {31'd0, lcd_line}, 32'd0);
      check("reset_busy", {31'd0, busy}, 32'd1);
      rd_addr = 5'h1F; #1;
      check("reset_rd_data", {24'd0, rd_data}, 32'h20);

      // Blank screen after reset: line 0 then line 1.
      push_line(0); push_line(1);
      auto_en = 1'b1;
      reset = 1'b0;
      wait_idle("reset_stream");
      check("busy_after_stream", {31'd0, busy}, 32'd0);

      // Single write to line 1 only resends line 1.
      mem[5'h13] = 8'h41;
      do_write(5'h13, 8'h41, 1'b1, 1'b0);
      push_line(1);
      rd_addr = 5'h13; #1;
      check("rd_data_13", {24'd0, rd_data}, 32'h41);
      wait_idle("line1_write");

      // Rewrite line 0 mid-pass: current pass completes, then line 0 goes again.
      d = 8'($urandom_range(8'h7E, 8'h21));
      mem[0] = d;
      do_write(5'h00, d, 1'b1, 1'b0);
      push_line(0);
      base = req_count;
      wait_req(base + 8, "reach_col7");
      mem[2] = 8'h5A;
      do_write(5'h02, 8'h5A, 1'b1, 1'b0);
      push_line(0);
      wait_idle("midline_rewrite");

      // Random single-cell writes while idle.
      for (int i = 0; i < 20; i++) begin
         a = 5'($urandom_range(31, 0));
         d = 8'($urandom_range(8'h7E, 8'h21));
         mem[a] = d;
         do_write(a, d, 1'b1, 1'b0);
         push_line(int'(a[4]));
         wait_idle("random_write");
         rd_addr = 5'($urandom_range(31, 0)); #1;
         check("rd_data_random", {24'd0, rd_data}, {24'd0, mem[rd_addr]});
      end

      // clr beats a same-cycle write.
      blank_mem();
      do_write(5'h00, 8'h31, 1'b1, 1'b1);
      rd_addr = 5'h00; #1;
      check("clr_priority", {24'd0, rd_data}, 32'h20);
      push_line(0); push_line(1);
      wait_idle("clr_stream");

      // A done level held high advances exactly one column.
      auto_en = 1'b0;
      d = 8'($urandom_range(8'h7E, 8'h21));
      mem[16] = d;
      do_write(5'h10, d, 1'b1, 1'b0);
      push_line(1);
      base = req_count;
      wait_req(base + 1, "first_req_held");
      @(negedge clock);
      hold_done = 1'b1;
      lat = 0;
      while (lcd_flag && lat < 10) begin
         @(negedge clock);
         lat++;
      end
      check("flag_low_latency_le3", {31'd0, lat <= 3}, 32'd1);
      base = req_count;
      repeat (1000) @(negedge clock);
      check("held_done_one_advance", req_count - base, 32'd1);
      hold_done = 1'b0;
      auto_en = 1'b1;
      wait_idle("after_held_done");

      // Reset in the middle of line 1, column 9.
      blank_mem();
      do_write(5'h00, 8'h00, 1'b0, 1'b1);
      push_line(0); push_line(1);
      base = req_count;
      wait_req(base + 26, "reach_line1_col9");
      @(negedge clock);
      auto_en = 1'b0;
      reset = 1'b1;
      #1;
      check("midreset_flag", {31'd0, lcd_flag}, 32'd0);
      check("midreset_char", {24'd0, lcd_char}, 32'd0);
      check("midreset_line", {31'd0, lcd_line}, 32'd0);
      check("midreset_busy", {31'd0, busy}, 32'd1);
      exp_q.delete();
      repeat (3) @(negedge clock);
      push_line(0); push_line(1);
      reset = 1'b0;
      auto_en = 1'b1;
      wait_idle("post_reset_stream");
      check("final_busy", {31'd0, busy}, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
